// File: rtl/dfh_chain_responder.sv
// MMIO responder that serves a parameterised Device Feature Header chain plus
// one 64-bit scratch register per feature, with credit-gated pipelined reads.
module dfh_chain_responder #(
  parameter int NUM_FEATURES = 4,
  parameter int ADDR_W       = 20,
  parameter logic [NUM_FEATURES*24-1:0] FEATURE_OFFSET = {24'h0, 24'h1000, 24'h3000, 24'h10000},
  parameter logic [NUM_FEATURES*12-1:0] FEATURE_ID     = {12'h0, 12'h1, 12'h2, 12'h3},
  parameter logic [NUM_FEATURES*4-1:0]  FEATURE_TYPE   = {4'h4, 4'h3, 4'h3, 4'h3},
  parameter logic [NUM_FEATURES*4-1:0]  FEATURE_REV    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [9:0]        req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [63:0]       rsp_data,
  output logic [9:0]        rsp_tag,
  output logic [7:0]        err_cnt
);

  localparam int IDX_W = 4;
  localparam int DEPTH = 4;
  localparam logic [1:0] KIND_NONE = 2'd0;
  localparam logic [1:0] KIND_DFH  = 2'd1;
  localparam logic [1:0] KIND_SCR  = 2'd2;

  // Packed parameters list feature 0 in the most significant slot.
  function automatic logic [23:0] feat_off(input int i);
    return FEATURE_OFFSET[(NUM_FEATURES-1-i)*24 +: 24];
  endfunction

  function automatic logic [63:0] dfh_value(input int i);
    logic [23:0] next_len;
    logic        eol;
    if (i == NUM_FEATURES-1) begin
      next_len = 24'h0;
      eol      = 1'b1;
    end else begin
      next_len = feat_off(i+1) - feat_off(i);
      eol      = 1'b0;
    end
    return {FEATURE_TYPE[(NUM_FEATURES-1-i)*4 +: 4], 8'h0, 11'h0, eol, next_len,
            FEATURE_REV[(NUM_FEATURES-1-i)*4 +: 4], FEATURE_ID[(NUM_FEATURES-1-i)*12 +: 12]};
  endfunction

  logic [63:0] dfh_word [NUM_FEATURES];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_FEATURES; gi++) begin : g_dfh
      localparam logic [63:0] DFH_WORD = dfh_value(gi);
      assign dfh_word[gi] = DFH_WORD;
    end
  endgenerate

  // Request-side decode
  logic [31:0]      addr_ext;
  logic             hit_dfh;
  logic             hit_scr;
  logic [IDX_W-1:0] hit_idx;
  logic             map_ok;
  logic             accept;
  logic             rd_acc;
  logic             scr_wr;

  always_comb begin
    hit_dfh  = 1'b0;
    hit_scr  = 1'b0;
    hit_idx  = '0;
    addr_ext = 32'(req_addr);
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (addr_ext == 32'(feat_off(i)) + 32'd8) begin
        hit_scr = 1'b1;
        hit_idx = IDX_W'(i);
      end
      if (addr_ext == 32'(feat_off(i))) begin
        hit_dfh = 1'b1;
        hit_scr = 1'b0;
        hit_idx = IDX_W'(i);
      end
    end
  end

  assign map_ok    = (hit_dfh || hit_scr) && (req_addr[2:0] == 3'b000);
  assign accept    = req_valid && req_ready;
  assign rd_acc    = accept && !req_write;
  assign scr_wr    = accept && req_write && map_ok && hit_scr;

  // State
  logic [2:0]       outstanding_q, outstanding_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic [63:0]      scratch_q [NUM_FEATURES];
  logic [63:0]      scratch_d [NUM_FEATURES];
  logic             s1_valid_q, s1_valid_d;
  logic [1:0]       s1_kind_q, s1_kind_d;
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [9:0]       s1_tag_q, s1_tag_d;
  logic             s2_valid_q, s2_valid_d;
  logic [63:0]      s2_data_q, s2_data_d;
  logic [9:0]       s2_tag_q, s2_tag_d;
  logic [1:0]       wr_ptr_q, wr_ptr_d;
  logic [1:0]       rd_ptr_q, rd_ptr_d;
  logic [2:0]       count_q, count_d;
  logic [63:0]      fifo_data_mem [DEPTH];
  logic [9:0]       fifo_tag_mem  [DEPTH];
  logic             push;
  logic             pop;

  // Credits count everything in s1, s2 and the FIFO, so the FIFO cannot overflow.
  assign req_ready = !rst && (outstanding_q < 3'd4);
  assign rsp_valid = (count_q != 3'd0);
  assign rsp_data  = rsp_valid ? fifo_data_mem[rd_ptr_q] : 64'h0;
  assign rsp_tag   = rsp_valid ? fifo_tag_mem[rd_ptr_q]  : 10'h0;
  assign err_cnt   = err_cnt_q;
  assign push      = s2_valid_q;
  assign pop       = rsp_valid && rsp_ready;

  always_comb begin
    s1_valid_d = rd_acc;
    s1_kind_d  = KIND_NONE;
    if (map_ok) s1_kind_d = hit_dfh ? KIND_DFH : KIND_SCR;
    s1_idx_d   = hit_idx;
    s1_tag_d   = req_tag;

    s2_valid_d = s1_valid_q;
    s2_tag_d   = s1_tag_q;
    s2_data_d  = 64'h0;
    for (int i = 0; i < NUM_FEATURES; i++) begin
      if (s1_idx_q == IDX_W'(i)) begin
        if (s1_kind_q == KIND_DFH) s2_data_d = dfh_word[i];
        else if (s1_kind_q == KIND_SCR) s2_data_d = scratch_q[i];
      end
    end

    for (int i = 0; i < NUM_FEATURES; i++) begin
      scratch_d[i] = scratch_q[i];
      if (scr_wr && hit_idx == IDX_W'(i)) scratch_d[i] = req_wdata;
    end

    err_cnt_d = err_cnt_q;
    if (accept && !map_ok && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;

    outstanding_d = outstanding_q + {2'b00, rd_acc} - {2'b00, pop};
    count_d       = count_q + {2'b00, push} - {2'b00, pop};
    wr_ptr_d      = push ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d      = pop  ? rd_ptr_q + 2'd1 : rd_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding_q <= '0;
      err_cnt_q     <= '0;
      for (int i = 0; i < NUM_FEATURES; i++) scratch_q[i] <= '0;
      s1_valid_q    <= 1'b0;
      s1_kind_q     <= KIND_NONE;
      s1_idx_q      <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_data_q     <= '0;
      s2_tag_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      err_cnt_q     <= err_cnt_d;
      for (int i = 0; i < NUM_FEATURES; i++) scratch_q[i] <= scratch_d[i];
      s1_valid_q    <= s1_valid_d;
      s1_kind_q     <= s1_kind_d;
      s1_idx_q      <= s1_idx_d;
      s1_tag_q      <= s1_tag_d;
      s2_valid_q    <= s2_valid_d;
      s2_data_q     <= s2_data_d;
      s2_tag_q      <= s2_tag_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  // Response storage needs no reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data_mem[wr_ptr_q] <= s2_data_q;
      fifo_tag_mem[wr_ptr_q]  <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_dfh_chain_responder.sv
// Directed bench for dfh_chain_responder: chain walk, scratch, errors,
// backpressure, latency/throughput and mid-operation reset.
module tb_dfh_chain_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [19:0] req_addr;
  logic [63:0] req_wdata;
  logic [9:0]  req_tag;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic [9:0]  rsp_tag;
  logic [7:0]  err_cnt;

  localparam logic [63:0] DFH0 = 64'h4000_0000_1000_0000;
  localparam logic [63:0] DFH1 = 64'h3000_0000_2000_0001;
  localparam logic [63:0] DFH2 = 64'h3000_0000_D000_0002;
  localparam logic [63:0] DFH3 = 64'h3000_0100_0000_0003;
  localparam logic [63:0] SCR1 = 64'hDEAD_BEEF_0123_4567;

  int vec = 0;
  int miscmp = 0;
  int cyc = 0;
  int last_acc = 0;

  logic [63:0] got_data [$];
  logic [9:0]  got_tag  [$];
  int          got_cyc  [$];

  dfh_chain_responder dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_tag(rsp_tag), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Records each response that will handshake on the coming rising edge.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      got_data.push_back(rsp_data);
      got_tag.push_back(rsp_tag);
      got_cyc.push_back(cyc);
      $display("rsp  cyc=%0d tag=%h data=%h", cyc, rsp_tag, rsp_data);
    end
  end

  task automatic clear_rsps();
    got_data.delete();
    got_tag.delete();
    got_cyc.delete();
  endtask

  task automatic issue(input logic wr, input logic [19:0] addr, input logic [63:0] wd,
                       input logic [9:0] tag);
    int n;
    n = 0;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_tag   = tag;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!req_ready) begin
      vec++;
      miscmp++;
      $display("FAIL issue_ready_timeout addr=%h req_ready=%0b want 1", addr, req_ready);
    end
    @(posedge clk);
    #1;
    last_acc  = cyc;
    req_valid = 1'b0;
    $display("req  cyc=%0d wr=%0b addr=%h tag=%h wdata=%h", cyc, wr, addr, tag, wd);
  endtask

  task automatic wait_rsps(input int n);
    int k;
    k = 0;
    while (got_data.size() < n && k < 100) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    vec++; if (req_ready !== 1'b1) begin miscmp++; $display("FAIL reset_req_ready got=%0b want=1", req_ready); end
    vec++; if (rsp_valid !== 1'b0) begin miscmp++; $display("FAIL reset_rsp_valid got=%0b want=0", rsp_valid); end
    vec++; if (rsp_data !== 64'h0) begin miscmp++; $display("FAIL reset_rsp_data got=%h want=0", rsp_data); end
    vec++; if (rsp_tag !== 10'h0) begin miscmp++; $display("FAIL reset_rsp_tag got=%h want=0", rsp_tag); end
    vec++; if (err_cnt !== 8'h0) begin miscmp++; $display("FAIL reset_err_cnt got=%h want=0", err_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_chain_walk();
    logic [19:0] addrs [4];
    logic [63:0] exp_d [4];
    addrs = '{20'h0, 20'h1000, 20'h3000, 20'h10000};
    exp_d = '{DFH0, DFH1, DFH2, DFH3};
    clear_rsps();
    for (int i = 0; i < 4; i++) issue(1'b0, addrs[i], 64'h0, 10'(i + 1));
    wait_rsps(4);
    vec++; if (got_data.size() !== 4) begin miscmp++; $display("FAIL chain_count got=%0d want=4", got_data.size()); end
    for (int i = 0; i < 4; i++) begin
      if (got_data.size() > i) begin
        vec++; if (got_data[i] !== exp_d[i]) begin miscmp++; $display("FAIL chain_data%0d got=%h want=%h", i, got_data[i], exp_d[i]); end
        vec++; if (got_tag[i] !== 10'(i + 1)) begin miscmp++; $display("FAIL chain_tag%0d got=%h want=%h", i, got_tag[i], 10'(i + 1)); end
      end
    end
  endtask

  task automatic test_scratch();
    clear_rsps();
    issue(1'b1, 20'h1008, SCR1, 10'h0);
    issue(1'b0, 20'h1008, 64'h0, 10'h2A);
    issue(1'b0, 20'h3008, 64'h0, 10'h2B);
    wait_rsps(2);
    vec++; if (got_data.size() !== 2) begin miscmp++; $display("FAIL scratch_count got=%0d want=2", got_data.size()); end
    if (got_data.size() >= 2) begin
      vec++; if (got_data[0] !== SCR1) begin miscmp++; $display("FAIL scratch_raw_data got=%h want=%h", got_data[0], SCR1); end
      vec++; if (got_tag[0] !== 10'h2A) begin miscmp++; $display("FAIL scratch_raw_tag got=%h want=2a", got_tag[0]); end
      vec++; if (got_data[1] !== 64'h0) begin miscmp++; $display("FAIL scratch_other_data got=%h want=0", got_data[1]); end
      vec++; if (got_tag[1] !== 10'h2B) begin miscmp++; $display("FAIL scratch_other_tag got=%h want=2b", got_tag[1]); end
    end
    vec++; if (err_cnt !== 8'h0) begin miscmp++; $display("FAIL scratch_err_cnt got=%h want=0", err_cnt); end
  endtask

  task automatic test_errors();
    clear_rsps();
    issue(1'b1, 20'h0, 64'hFFFF_FFFF_FFFF_FFFF, 10'h0);
    issue(1'b0, 20'h0, 64'h0, 10'h5);
    issue(1'b0, 20'h500, 64'h0, 10'h6);
    issue(1'b0, 20'h1004, 64'h0, 10'h7);
    issue(1'b1, 20'h2000, 64'h1234, 10'h0);
    wait_rsps(3);
    vec++; if (got_data.size() !== 3) begin miscmp++; $display("FAIL err_count_rsps got=%0d want=3", got_data.size()); end
    if (got_data.size() >= 3) begin
      vec++; if (got_data[0] !== DFH0) begin miscmp++; $display("FAIL err_dfh_write_dropped got=%h want=%h", got_data[0], DFH0); end
      vec++; if (got_data[1] !== 64'h0) begin miscmp++; $display("FAIL err_unmapped_data got=%h want=0", got_data[1]); end
      vec++; if (got_data[2] !== 64'h0) begin miscmp++; $display("FAIL err_misaligned_data got=%h want=0", got_data[2]); end
      vec++; if (got_tag[2] !== 10'h7) begin miscmp++; $display("FAIL err_misaligned_tag got=%h want=7", got_tag[2]); end
    end
    vec++; if (err_cnt !== 8'h03) begin miscmp++; $display("FAIL err_cnt_3 got=%h want=03", err_cnt); end
    for (int i = 0; i < 251; i++) issue(1'b1, 20'h2000, 64'h0, 10'h0);
    vec++; if (err_cnt !== 8'hFE) begin miscmp++; $display("FAIL err_cnt_254 got=%h want=fe", err_cnt); end
    for (int i = 0; i < 46; i++) issue(1'b1, 20'h2000, 64'h0, 10'h0);
    vec++; if (err_cnt !== 8'hFF) begin miscmp++; $display("FAIL err_cnt_sat got=%h want=ff", err_cnt); end
  endtask

  task automatic test_backpressure();
    logic [19:0] addrs [5];
    logic [63:0] exp_d [5];
    addrs = '{20'h0, 20'h1000, 20'h3000, 20'h10000, 20'h1008};
    exp_d = '{DFH0, DFH1, DFH2, DFH3, SCR1};
    clear_rsps();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) issue(1'b0, addrs[i], 64'h0, 10'h10 + 10'(i));
    vec++; if (req_ready !== 1'b0) begin miscmp++; $display("FAIL bp_req_ready_low got=%0b want=0", req_ready); end
    repeat (3) @(posedge clk);
    @(negedge clk);
    vec++; if (rsp_valid !== 1'b1) begin miscmp++; $display("FAIL bp_hold_valid got=%0b want=1", rsp_valid); end
    vec++; if (rsp_data !== DFH0) begin miscmp++; $display("FAIL bp_hold_data got=%h want=%h", rsp_data, DFH0); end
    vec++; if (rsp_tag !== 10'h10) begin miscmp++; $display("FAIL bp_hold_tag got=%h want=10", rsp_tag); end
    vec++; if (req_ready !== 1'b0) begin miscmp++; $display("FAIL bp_still_blocked got=%0b want=0", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = addrs[4]; req_tag = 10'h14;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    vec++; if (req_ready !== 1'b1) begin miscmp++; $display("FAIL bp_ready_reassert got=%0b want=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_rsps(5);
    vec++; if (got_data.size() !== 5) begin miscmp++; $display("FAIL bp_count got=%0d want=5", got_data.size()); end
    for (int i = 0; i < 5; i++) begin
      if (got_data.size() > i) begin
        vec++; if (got_data[i] !== exp_d[i]) begin miscmp++; $display("FAIL bp_data%0d got=%h want=%h", i, got_data[i], exp_d[i]); end
        vec++; if (got_tag[i] !== 10'h10 + 10'(i)) begin miscmp++; $display("FAIL bp_tag%0d got=%h want=%h", i, got_tag[i], 10'h10 + 10'(i)); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [19:0] addrs [8];
    logic [63:0] exp_d [8];
    int first_acc;
    addrs = '{20'h0, 20'h1000, 20'h3000, 20'h10000, 20'h1008, 20'h3008, 20'h0, 20'h1000};
    exp_d = '{DFH0, DFH1, DFH2, DFH3, SCR1, 64'h0, DFH0, DFH1};
    clear_rsps();
    rsp_ready = 1'b1;
    first_acc = 0;
    for (int i = 0; i < 8; i++) begin
      issue(1'b0, addrs[i], 64'h0, 10'h100 + 10'(i));
      if (i == 0) first_acc = last_acc;
    end
    wait_rsps(8);
    vec++; if (got_data.size() !== 8) begin miscmp++; $display("FAIL b2b_count got=%0d want=8", got_data.size()); end
    if (got_data.size() >= 8) begin
      vec++; if (got_cyc[0] !== first_acc + 2) begin miscmp++; $display("FAIL b2b_latency got=%0d want=%0d", got_cyc[0], first_acc + 2); end
      for (int i = 0; i < 8; i++) begin
        vec++; if (got_data[i] !== exp_d[i]) begin miscmp++; $display("FAIL b2b_data%0d got=%h want=%h", i, got_data[i], exp_d[i]); end
        vec++; if (got_tag[i] !== 10'h100 + 10'(i)) begin miscmp++; $display("FAIL b2b_tag%0d got=%h want=%h", i, got_tag[i], 10'h100 + 10'(i)); end
        if (i > 0) begin
          vec++; if (got_cyc[i] !== first_acc + 2 + i) begin miscmp++; $display("FAIL b2b_gap%0d got=%0d want=%0d", i, got_cyc[i], first_acc + 2 + i); end
        end
      end
    end
  endtask

  task automatic test_reset_midop();
    clear_rsps();
    issue(1'b1, 20'h3008, 64'h55, 10'h0);
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 20'h0, 64'h0, 10'h30 + 10'(i));
    @(negedge clk);
    rst = 1'b1;
    #1;
    vec++; if (rsp_valid !== 1'b0) begin miscmp++; $display("FAIL rst_mid_valid got=%0b want=0", rsp_valid); end
    vec++; if (rsp_data !== 64'h0) begin miscmp++; $display("FAIL rst_mid_data got=%h want=0", rsp_data); end
    vec++; if (err_cnt !== 8'h0) begin miscmp++; $display("FAIL rst_mid_err got=%h want=0", err_cnt); end
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    vec++; if (got_data.size() !== 0) begin miscmp++; $display("FAIL rst_stale_rsps got=%0d want=0", got_data.size()); end
    @(posedge clk); #1;
    issue(1'b0, 20'h3008, 64'h0, 10'h3A);
    issue(1'b0, 20'h1008, 64'h0, 10'h3B);
    wait_rsps(2);
    vec++; if (got_data.size() !== 2) begin miscmp++; $display("FAIL rst_post_count got=%0d want=2", got_data.size()); end
    if (got_data.size() >= 2) begin
      vec++; if (got_data[0] !== 64'h0) begin miscmp++; $display("FAIL rst_scr3_data got=%h want=0", got_data[0]); end
      vec++; if (got_data[1] !== 64'h0) begin miscmp++; $display("FAIL rst_scr1_data got=%h want=0", got_data[1]); end
      vec++; if (got_tag[1] !== 10'h3B) begin miscmp++; $display("FAIL rst_post_tag got=%h want=3b", got_tag[1]); end
    end
  endtask

  initial begin
    test_reset();
    test_chain_walk();
    test_scratch();
    test_errors();
    test_backpressure();
    test_back_to_back();
    test_reset_midop();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout cyc=%0d want finish before limit", cyc);
    $fatal(1, "watchdog");
  end

endmodule
